gtech_parity_chk: RTL

// Receive-side parity checker for words whose parity bit was generated

---
 rtl/gtech_parity_chk.sv | 121 ++++++++++++
 1 files changed

// File: rtl/gtech_parity_chk.sv
// Receive-side parity checker: flags each {data, parity} word, forwards it through
// a 2-entry skid buffer, and keeps a saturating error count plus a sticky error flag.
module gtech_parity_chk #(
    parameter int DW    = 8,
    parameter bit ODD   = 1'b1,
    parameter int CNT_W = 8
) (
    input  logic             CP,
    input  logic             CD,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             in_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_err,
    input  logic             clr,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic             rdy_q, rdy_d;
    // Each entry is {err, data}; slot0 always holds the oldest word.
    logic [DW:0]      slot0_q, slot0_d;
    logic [DW:0]      slot1_q, slot1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic             sticky_q, sticky_d;

    logic             par_x;
    logic             word_err;
    logic [DW:0]      in_word;
    logic             accept;
    logic             pop;

    assign par_x    = ^{in_data, in_par};
    assign word_err = ODD ? ~par_x : par_x;
    assign in_word  = {word_err, in_data};

    assign accept = in_valid & rdy_q;
    assign pop    = (state_q != EMPTY) & out_ready;

    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    slot0_d = in_word;
                end
            end
            ONE: begin
                case ({accept, pop})
                    2'b10: begin
                        state_d = TWO;
                        slot1_d = in_word;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: slot0_d = in_word;
                    default: ;
                endcase
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    slot0_d = slot1_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Ready is registered from the next occupancy so it never depends on out_ready.
    assign rdy_d = (state_d != TWO);

    // Clear takes effect first, so a same-cycle error still counts as one.
    always_comb begin
        cnt_base = clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (accept && word_err && (cnt_base != CNT_MAX))
            cnt_d = cnt_base + CNT_W'(1);
        sticky_d = (clr ? 1'b0 : sticky_q) | (accept & word_err);
    end

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            state_q  <= EMPTY;
            rdy_q    <= 1'b0;
            slot0_q  <= '0;
            slot1_q  <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            slot0_q  <= slot0_d;
            slot1_q  <= slot1_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign in_ready   = rdy_q;
    assign out_valid  = (state_q != EMPTY);
    assign out_data   = slot0_q[DW-1:0];
    assign out_err    = slot0_q[DW];
    assign err_cnt    = cnt_q;
    assign err_sticky = sticky_q;

endmodule
